hazard_stall_controller: RTL

- Drives the write enables and bubble/flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Pipeline registers sample these controls on the next posedge clk, so their wr_en and bubble inputs are this block's outputs.
- Detects load-use RAW hazards, freezes the front end for multi-cycle EX operations, and squashes wrong-path instructions on taken branches/jumps resolved in EX.

---
 rtl/hazard_stall_controller_pkg.sv | 19 +
 rtl/hazard_stall_controller_raw_detect.sv | 23 ++
 rtl/hazard_stall_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// State encoding, register-address width and the hard-wired zero register.
package hazard_stall_controller_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MULTI_BUSY = 2'd2
    } hazard_state_t;

    // A destination only creates a dependency when it is not the zero register.
    function automatic logic is_real_dest(input logic [REG_ADDR_W-1:0] rd);
        return rd != REG_ZERO;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_raw_detect.sv
// Combinational load-use RAW detector: flags an ID instruction that reads the
// register a load currently in EX is about to write.
module hazard_raw_detect
    import hazard_stall_controller_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_address,
    input  logic [REG_ADDR_W-1:0] id_rs2_address,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_address,
    input  logic                  ex_reg_wr_en,
    input  logic                  ex_is_load,
    output logic                  load_use
);

    // Match either used source operand against a live load destination.
    always_comb begin
        load_use = ex_is_load & ex_reg_wr_en & is_real_dest(ex_rd_address) &
                   ((id_rs1_used & (id_rs1_address == ex_rd_address)) |
                    (id_rs2_used & (id_rs2_address == ex_rd_address)));
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: drives PC, IF/ID, ID/EX and EX/MEM
// write-enable and bubble/flush controls for load-use stalls, multi-cycle EX
// operations and taken branches resolved in EX.
// Optional build macro HAZARD_PERF_EN adds stall and flush event counters.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int LOAD_LAT  = 1,
    parameter int MULTI_LAT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_address,
    input  logic [REG_ADDR_W-1:0] id_rs2_address,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_address,
    input  logic                  ex_reg_wr_en,
    input  logic                  ex_is_load,
    input  logic                  ex_multi_start,
    input  logic                  ex_branch_taken,
    output logic                  pc_wr_en,
    output logic                  if_id_wr_en,
    output logic                  if_id_flush,
    output logic                  id_ex_wr_en,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
`ifdef HAZARD_PERF_EN
    output logic [31:0]           stall_cycle_count,
    output logic [31:0]           flush_count,
`endif
    output logic                  busy
);

    localparam logic [3:0] LOAD_INIT  = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
    localparam logic [3:0] MULTI_INIT = 4'(MULTI_LAT - 2);

    hazard_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          load_use;
    logic          run_eval;
    logic          pc_wr_en_c, if_id_wr_en_c, if_id_flush_c;
    logic          id_ex_wr_en_c, id_ex_bubble_c, ex_mem_bubble_c;

    hazard_raw_detect u_raw_detect (
        .id_rs1_address (id_rs1_address),
        .id_rs2_address (id_rs2_address),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .ex_rd_address  (ex_rd_address),
        .ex_reg_wr_en   (ex_reg_wr_en),
        .ex_is_load     (ex_is_load),
        .load_use       (load_use)
    );

    // Next-state and raw control decode; the final MULTI_BUSY cycle reuses the RUN priority chain.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        run_eval        = 1'b0;
        pc_wr_en_c      = 1'b1;
        if_id_wr_en_c   = 1'b1;
        if_id_flush_c   = 1'b0;
        id_ex_wr_en_c   = 1'b1;
        id_ex_bubble_c  = 1'b0;
        ex_mem_bubble_c = 1'b0;
        case (state_q)
            RUN: run_eval = 1'b1;
            LOAD_STALL: begin
                pc_wr_en_c     = 1'b0;
                if_id_wr_en_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
                if (cnt_q == 4'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            MULTI_BUSY: begin
                if (cnt_q == 4'd0) begin
                    run_eval = 1'b1;
                end else begin
                    pc_wr_en_c      = 1'b0;
                    if_id_wr_en_c   = 1'b0;
                    id_ex_wr_en_c   = 1'b0;
                    ex_mem_bubble_c = 1'b1;
                    cnt_d           = cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
        if (run_eval) begin
            state_d = RUN;
            if (ex_branch_taken) begin
                if_id_flush_c  = 1'b1;
                id_ex_bubble_c = 1'b1;
            end else if (ex_multi_start) begin
                pc_wr_en_c      = 1'b0;
                if_id_wr_en_c   = 1'b0;
                id_ex_wr_en_c   = 1'b0;
                ex_mem_bubble_c = 1'b1;
                state_d         = MULTI_BUSY;
                cnt_d           = MULTI_INIT;
            end else if (load_use) begin
                pc_wr_en_c     = 1'b0;
                if_id_wr_en_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_d = LOAD_STALL;
                    cnt_d   = LOAD_INIT;
                end
            end
        end
    end

    // Reset forces every pipeline register to hold and load bubbles, independent of the clock.
    always_comb begin
        if (reset) begin
            pc_wr_en      = 1'b0;
            if_id_wr_en   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_wr_en   = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            busy          = 1'b0;
        end else begin
            pc_wr_en      = pc_wr_en_c;
            if_id_wr_en   = if_id_wr_en_c;
            if_id_flush   = if_id_flush_c;
            id_ex_wr_en   = id_ex_wr_en_c;
            id_ex_bubble  = id_ex_bubble_c;
            ex_mem_bubble = ex_mem_bubble_c;
            busy          = (state_q != RUN);
        end
    end

    // State and stall counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycle_count_q, stall_cycle_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Count frozen-PC cycles and IF/ID flush cycles; both wrap naturally.
    always_comb begin
        stall_cycle_count_d = stall_cycle_count_q + {31'd0, ~pc_wr_en};
        flush_count_d       = flush_count_q + {31'd0, if_id_flush};
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycle_count_q <= 32'd0;
            flush_count_q       <= 32'd0;
        end else begin
            stall_cycle_count_q <= stall_cycle_count_d;
            flush_count_q       <= flush_count_d;
        end
    end

    assign stall_cycle_count = stall_cycle_count_q;
    assign flush_count       = flush_count_q;
`endif

endmodule
